// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the RAM command arbiter: opcodes, FSM states and the
// default command-word width.
package ram_arb_pkg;

    localparam int unsigned AddrSizeDef = 8;

    // Opcode occupies the top two bits of the RAM command word
    localparam logic [1:0] OpWAdd  = 2'd0;
    localparam logic [1:0] OpWData = 2'd1;
    localparam logic [1:0] OpRAdd  = 2'd2;
    localparam logic [1:0] OpRData = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StWait,
        StResp
    } state_e;

endpackage

// File: rtl/ram_arb_rr.sv
// Two-way grant selector. Round-robin when RAM_ARB_RR_EN is defined, otherwise
// fixed priority to requester 0 with no state.
module ram_arb_rr (
`ifdef RAM_ARB_RR_EN
    input  logic       clk,
    input  logic       rst,
`endif
    input  logic [1:0] req,
    output logic [1:0] gnt
);

`ifdef RAM_ARB_RR_EN
    logic prio_q;  // 1: requester 1 wins a tie

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = prio_q ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else if (|gnt) begin
            prio_q <= gnt[0];
        end
    end
`else
    always_comb begin
        gnt = req[0] ? 2'b01 : {req[1], 1'b0};
    end
`endif

endmodule

// File: rtl/ram_cmd_arbiter.sv
// Arbitrates two requesters onto a single RAM command port and routes the response back.
// Define RAM_ARB_RR_EN for round-robin arbitration; default is fixed priority to requester 0.
module ram_cmd_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = AddrSizeDef,
    parameter int unsigned TMO_CYC   = 4
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic                 req0_wr,
    input  logic [ADDR_SIZE-1:0] req0_addr,
    input  logic [ADDR_SIZE-1:0] req0_wdata,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic                 req1_wr,
    input  logic [ADDR_SIZE-1:0] req1_addr,
    input  logic [ADDR_SIZE-1:0] req1_wdata,

    output logic                 rsp0_valid,
    output logic [ADDR_SIZE-1:0] rsp0_rdata,
    output logic                 rsp0_err,

    output logic                 rsp1_valid,
    output logic [ADDR_SIZE-1:0] rsp1_rdata,
    output logic                 rsp1_err,

    output logic [ADDR_SIZE+1:0] ram_din,
    output logic                 ram_rx_valid,
    input  logic [ADDR_SIZE-1:0] ram_dout,
    input  logic                 ram_tx_valid,
    output logic                 busy
);

    localparam int unsigned TmoW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    state_e                state_q, state_d;
    logic                  wr_q, wr_d;
    logic [ADDR_SIZE-1:0]  addr_q, addr_d;
    logic [ADDR_SIZE-1:0]  wdata_q, wdata_d;
    logic [ADDR_SIZE-1:0]  rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  idx_q, idx_d;
    logic [TmoW-1:0]       tmo_q, tmo_d;

    logic [1:0]            arb_req;
    logic [1:0]            gnt;
    logic                  tmo_last;

    // Requests only count in IDLE and never while reset is held, so ready stays low in reset
    assign arb_req  = {req1_valid, req0_valid} & {2{(state_q == StIdle) && !rst}};
    assign tmo_last = (tmo_q == TmoW'(TMO_CYC - 1));

    ram_arb_rr u_arb (
`ifdef RAM_ARB_RR_EN
        .clk (clk),
        .rst (rst),
`endif
        .req (arb_req),
        .gnt (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            StIdle: begin
                if (|gnt) begin
                    wr_d    = gnt[1] ? req1_wr    : req0_wr;
                    addr_d  = gnt[1] ? req1_addr  : req0_addr;
                    wdata_d = gnt[1] ? req1_wdata : req0_wdata;
                    idx_d   = gnt[1];
                    rdata_d = '0;
                    err_d   = 1'b0;
                    tmo_d   = '0;
                    state_d = StAddr;
                end
            end
            StAddr: state_d = StData;
            StData: begin
                tmo_d   = '0;
                state_d = wr_q ? StResp : StWait;
            end
            StWait: begin
                if (ram_tx_valid) begin
                    rdata_d = ram_dout;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (tmo_last) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            idx_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        ram_din      = '0;
        ram_rx_valid = 1'b0;
        unique case (state_q)
            StAddr: begin
                ram_din      = {(wr_q ? OpWAdd : OpRAdd), addr_q};
                ram_rx_valid = 1'b1;
            end
            StData: begin
                ram_din      = wr_q ? {OpWData, wdata_q} : {OpRData, {ADDR_SIZE{1'b0}}};
                ram_rx_valid = 1'b1;
            end
            default: begin
                ram_din      = '0;
                ram_rx_valid = 1'b0;
            end
        endcase
    end

    always_comb begin
        rsp0_valid = (state_q == StResp) && !idx_q;
        rsp1_valid = (state_q == StResp) && idx_q;
        rsp0_rdata = rsp0_valid ? rdata_q : '0;
        rsp1_rdata = rsp1_valid ? rdata_q : '0;
        rsp0_err   = rsp0_valid & err_q;
        rsp1_err   = rsp1_valid & err_q;
        busy       = (state_q != StIdle);
    end

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Directed self-checking bench for ram_cmd_arbiter; expectations adapt to RAM_ARB_RR_EN.
module tb_ram_cmd_arbiter;

    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req0_ready, req0_wr = 1'b0;
    logic [AW-1:0] req0_addr = '0, req0_wdata = '0;
    logic          req1_valid = 1'b0, req1_ready, req1_wr = 1'b0;
    logic [AW-1:0] req1_addr = '0, req1_wdata = '0;
    logic          rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [AW-1:0] rsp0_rdata, rsp1_rdata;
    logic [AW+1:0] ram_din;
    logic          ram_rx_valid, busy;
    logic [AW-1:0] ram_dout = '0;
    logic          ram_tx_valid = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_cmd_arbiter #(.ADDR_SIZE(AW), .TMO_CYC(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_wr      (req0_wr),
        .req0_addr    (req0_addr),
        .req0_wdata   (req0_wdata),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_wr      (req1_wr),
        .req1_addr    (req1_addr),
        .req1_wdata   (req1_wdata),
        .rsp0_valid   (rsp0_valid),
        .rsp0_rdata   (rsp0_rdata),
        .rsp0_err     (rsp0_err),
        .rsp1_valid   (rsp1_valid),
        .rsp1_rdata   (rsp1_rdata),
        .rsp1_err     (rsp1_err),
        .ram_din      (ram_din),
        .ram_rx_valid (ram_rx_valid),
        .ram_dout     (ram_dout),
        .ram_tx_valid (ram_tx_valid),
        .busy         (busy)
    );

    // Packed view of every output, used where all of them must be zero
    wire [2*AW+AW+AW+8:0] all_out = {req0_ready, req1_ready, rsp0_valid, rsp0_rdata, rsp0_err,
                                     rsp1_valid, rsp1_rdata, rsp1_err, ram_din, ram_rx_valid,
                                     busy};

    task automatic test_reset;
        req0_valid = 1'b1;
        #2;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", all_out);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL post_reset_idle got %h exp 0", all_out);
        end
    endtask

    task automatic test_write;
        @(negedge clk);
        req0_valid = 1'b1; req0_wr = 1'b1; req0_addr = 8'h12; req0_wdata = 8'hA5;
        #1;
        checks++;
        if ({req1_ready, req0_ready, busy} !== 3'b010) begin
            errors++;
            $display("FAIL wr_grant got %b exp 010", {req1_ready, req0_ready, busy});
        end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        checks++;
        if ({busy, req0_ready, ram_rx_valid, ram_din} !== {3'b101, 10'h012}) begin
            errors++;
            $display("FAIL wr_addr_phase got %h exp %h", {busy, req0_ready, ram_rx_valid, ram_din},
                     {3'b101, 10'h012});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({ram_rx_valid, ram_din} !== {1'b1, 10'h1A5}) begin
            errors++;
            $display("FAIL wr_data_phase got %h exp %h", {ram_rx_valid, ram_din}, {1'b1, 10'h1A5});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({rsp0_valid, rsp0_err, rsp0_rdata, rsp1_valid, ram_rx_valid} !== {2'b10, 8'h00, 2'b00}) begin
            errors++;
            $display("FAIL wr_rsp got %h exp %h", {rsp0_valid, rsp0_err, rsp0_rdata, rsp1_valid,
                     ram_rx_valid}, {2'b10, 8'h00, 2'b00});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({busy, rsp0_valid} !== 2'b00) begin
            errors++;
            $display("FAIL wr_done got %b exp 00", {busy, rsp0_valid});
        end
    endtask

    task automatic test_read;
        @(negedge clk);
        req1_valid = 1'b1; req1_wr = 1'b0; req1_addr = 8'h12; req1_wdata = 8'hFF;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            errors++;
            $display("FAIL rd_grant got %b exp 10", {req1_ready, req0_ready});
        end
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        checks++;
        if ({ram_rx_valid, ram_din} !== {1'b1, 10'h212}) begin
            errors++;
            $display("FAIL rd_addr_phase got %h exp %h", {ram_rx_valid, ram_din}, {1'b1, 10'h212});
        end
        // Stray strobe during DATA must be ignored
        @(negedge clk);
        ram_tx_valid = 1'b1; ram_dout = 8'h55;
        #1;
        checks++;
        if ({ram_rx_valid, ram_din} !== {1'b1, 10'h300}) begin
            errors++;
            $display("FAIL rd_data_phase got %h exp %h", {ram_rx_valid, ram_din}, {1'b1, 10'h300});
        end
        @(negedge clk);
        ram_dout = 8'hA5;
        #1;
        checks++;
        if ({busy, ram_rx_valid, ram_din, rsp1_valid} !== {2'b10, 10'h000, 1'b0}) begin
            errors++;
            $display("FAIL rd_wait got %h exp %h", {busy, ram_rx_valid, ram_din, rsp1_valid},
                     {2'b10, 10'h000, 1'b0});
        end
        @(negedge clk);
        ram_tx_valid = 1'b0; ram_dout = 8'h00;
        #1;
        checks++;
        if ({rsp1_valid, rsp1_err, rsp1_rdata, rsp0_valid, rsp0_rdata} !==
            {2'b10, 8'hA5, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL rd_rsp got %h exp %h", {rsp1_valid, rsp1_err, rsp1_rdata, rsp0_valid,
                     rsp0_rdata}, {2'b10, 8'hA5, 1'b0, 8'h00});
        end
    endtask

    task automatic test_arbitration;
        logic [1:0] exp_gnt;
        @(negedge clk);
        req0_valid = 1'b1; req0_wr = 1'b1; req0_addr = 8'h20; req0_wdata = 8'h01;
        req1_valid = 1'b1; req1_wr = 1'b1; req1_addr = 8'h30; req1_wdata = 8'h02;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
`ifdef RAM_ARB_RR_EN
            exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_gnt = 2'b01;
`endif
            #1;
            checks++;
            if ({req1_ready, req0_ready} !== exp_gnt) begin
                errors++;
                $display("FAIL arb_grant%0d got %b exp %b", i, {req1_ready, req0_ready}, exp_gnt);
            end
            repeat (2) @(negedge clk);
            @(negedge clk);
            #1;
            checks++;
            if ({rsp1_valid, rsp0_valid} !== exp_gnt) begin
                errors++;
                $display("FAIL arb_rsp%0d got %b exp %b", i, {rsp1_valid, rsp0_valid}, exp_gnt);
            end
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        checks++;
        if ({busy, req0_ready, req1_ready} !== 3'b000) begin
            errors++;
            $display("FAIL arb_idle got %b exp 000", {busy, req0_ready, req1_ready});
        end
    endtask

    task automatic test_timeout;
        @(negedge clk);
        req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = 8'h34;
        ram_dout = 8'h77; ram_tx_valid = 1'b0;
        @(negedge clk);
        req0_valid = 1'b0;
        // ADDR, DATA, then four WAIT cycles without a response
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if ({busy, rsp0_valid} !== 2'b10) begin
            errors++;
            $display("FAIL tmo_last_wait got %b exp 10", {busy, rsp0_valid});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({rsp0_valid, rsp0_err, rsp0_rdata} !== {2'b11, 8'h00}) begin
            errors++;
            $display("FAIL tmo_rsp got %h exp %h", {rsp0_valid, rsp0_err, rsp0_rdata}, {2'b11, 8'h00});
        end
        @(negedge clk);
        ram_dout = 8'h00;
        #1;
        checks++;
        if ({busy, rsp0_valid, rsp0_err} !== 3'b000) begin
            errors++;
            $display("FAIL tmo_done got %b exp 000", {busy, rsp0_valid, rsp0_err});
        end
    endtask

    task automatic test_reset_inflight;
        @(negedge clk);
        req0_valid = 1'b1; req0_wr = 1'b1; req0_addr = 8'h56; req0_wdata = 8'h99;
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({ram_rx_valid, ram_din} !== {1'b1, 10'h199}) begin
            errors++;
            $display("FAIL rst_pre_data got %h exp %h", {ram_rx_valid, ram_din}, {1'b1, 10'h199});
        end
        req1_valid = 1'b1; req1_wr = 1'b1; req1_addr = 8'h01; req1_wdata = 8'h02;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL rst_async got %h exp 0", all_out);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin
                errors++;
                $display("FAIL rst_no_rsp%0d got %b exp 000", i, {busy, rsp0_valid, rsp1_valid});
            end
        end
        @(negedge clk);
        req1_valid = 1'b1;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            errors++;
            $display("FAIL rst_regrant got %b exp 10", {req1_ready, req0_ready});
        end
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        checks++;
        if ({ram_rx_valid, ram_din} !== {1'b1, 10'h001}) begin
            errors++;
            $display("FAIL rst_new_addr got %h exp %h", {ram_rx_valid, ram_din}, {1'b1, 10'h001});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({ram_rx_valid, ram_din} !== {1'b1, 10'h102}) begin
            errors++;
            $display("FAIL rst_new_data got %h exp %h", {ram_rx_valid, ram_din}, {1'b1, 10'h102});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({rsp1_valid, rsp1_err, rsp1_rdata, rsp0_valid} !== {2'b10, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL rst_new_rsp got %h exp %h", {rsp1_valid, rsp1_err, rsp1_rdata, rsp0_valid},
                     {2'b10, 8'h00, 1'b0});
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_arbitration();
        test_timeout();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_cmd_arbiter.md
RAM_CMD_ARBITER -- requirements
Module: ram_cmd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 8, giving the address and data width of the RAM command word.
REQ-002 SHALL have parameter TMO_CYC, default 4, giving the maximum number of cycles to wait for read data.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have ports reqN_valid (in, 1), reqN_ready (out, 1), reqN_wr (in, 1), reqN_addr (in, ADDR_SIZE) and reqN_wdata (in, ADDR_SIZE), for N = 0 and 1: the requester command channel.
REQ-006 SHALL have ports rspN_valid (out, 1), rspN_rdata (out, ADDR_SIZE) and rspN_err (out, 1), for N = 0 and 1: the requester response channel.
REQ-007 SHALL have port ram_din, output, ADDR_SIZE+2 bits: RAM command word, {opcode[1:0], payload}.
REQ-008 SHALL have ports ram_rx_valid (out, 1), ram_dout (in, ADDR_SIZE), ram_tx_valid (in, 1) and busy (out, 1): RAM strobes, RAM read data, and transaction-in-flight flag.

Function
REQ-009 SHALL use opcodes W_ADD=0, W_DATA=1, R_ADD=2 and R_DATA=3.
REQ-010 SHALL use a Moore FSM with states IDLE, ADDR, DATA, WAIT and RESP, with all RAM-side outputs decoded from the registered state.
REQ-011 SHALL, in IDLE, drive ram_din=0 and ram_rx_valid=0.
REQ-012 SHALL, in IDLE with any reqN_valid, assert reqN_ready for one cycle to the single winner, capture wr/addr/wdata and the winner index, and move to ADDR.
REQ-013 SHALL treat a command as accepted only on valid&&ready; a requester holds valid and fields stable until then.
REQ-014 SHALL, in ADDR, drive ram_din={wr?W_ADD:R_ADD, addr} with ram_rx_valid=1, then move to DATA.
REQ-015 SHALL, in DATA, drive ram_din={W_DATA, wdata} for a write or {R_DATA, 0} for a read, with ram_rx_valid=1.
REQ-016 SHALL, from DATA, move a write to RESP and a read to WAIT.
REQ-017 SHALL, in WAIT, drive ram_din=0 and ram_rx_valid=0, and capture ram_dout on the first cycle ram_tx_valid=1, then move to RESP.
REQ-018 SHALL, if TMO_CYC cycles elapse in WAIT without ram_tx_valid, move to RESP with err=1 and rdata=0.
REQ-019 SHALL, in RESP, pulse rspN_valid for one cycle to the captured requester only, with rdata (0 for writes) and err, then return to IDLE.
REQ-020 SHALL give write latency from accept cycle C as rsp at C+3, and nominal read latency as rsp at C+4.
REQ-021 SHALL hold the winner's rsp fields stable during its rspN_valid pulse and drive the loser's rsp outputs to 0.
REQ-022 SHALL assert busy in every state except IDLE, and never assert reqN_ready outside IDLE.
REQ-023 SHALL ignore a ram_tx_valid that arrives outside WAIT.
REQ-024 SHALL allow a new grant in the IDLE cycle immediately following RESP.

Reset
REQ-025 SHALL, on rst=1 at any time, asynchronously force the state to IDLE and all outputs to 0, clear the timeout counter and captured fields, and set the round-robin pointer to favour requester 0.
REQ-026 SHALL drop any in-flight transaction on reset and never generate a response for it.

Configuration
REQ-027 SHALL, with RAM_ARB_RR_EN defined, arbitrate round-robin: when both requesters are valid, the one not granted last wins, and the pointer updates on every grant.
REQ-028 SHALL, without RAM_ARB_RR_EN, give requester 0 fixed priority, with no pointer register present.

Structure
REQ-029 SHALL place the opcode constants, the FSM state enum and the ADDR_SIZE default in package ram_arb_pkg.
REQ-030 SHALL implement grant selection in sub-module ram_arb_rr (2-way, with the macro-controlled policy) and instantiate it once.

Verification
REQ-031 SHALL cover: req0 write addr=0x12 data=0xA5 -> ram_din 0x012 then 0x1A5 with rx_valid high, rsp0_valid at C+3 with err=0.
REQ-032 SHALL cover: after REQ-031, req1 read addr=0x12 -> ram_din 0x212 then 0x300, rsp1_valid at C+4 with rdata=0xA5.
REQ-033 SHALL cover: both valid every cycle, with RAM_ARB_RR_EN defined -> grants alternate 0,1,0,1; undefined -> all grants to 0.
REQ-034 SHALL cover: read with ram_tx_valid held at 0 -> rsp_valid after TMO_CYC=4 WAIT cycles with err=1 and rdata=0.
REQ-035 SHALL cover: rst pulsed during DATA of a write -> all outputs 0 immediately, no rsp pulse, next request granted normally.
